// File: rtl/regfile_mp_if.sv
// Read/write port bundle for regfile_mp: per-port enables, addresses, data and scrub busy.
interface regfile_mp_if #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned WRITE_PORTS = 1
) ();
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                          busy;
  logic [READ_PORTS-1:0]         rs_en;
  logic [READ_PORTS*AW-1:0]      rs_sel;
  logic [READ_PORTS*WIDTH-1:0]   rs_out;
  logic [WRITE_PORTS-1:0]        rd_we;
  logic [WRITE_PORTS*AW-1:0]     rd_sel;
  logic [WRITE_PORTS*WIDTH-1:0]  rd_data;

  modport master (
    input  busy, rs_out,
    output rs_en, rs_sel, rd_we, rd_sel, rd_data
  );

  modport slave (
    output busy, rs_out,
    input  rs_en, rs_sel, rd_we, rd_sel, rd_data
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-first bypass and a post-reset scrub
// that zeroes every entry while busy is high.
module regfile_mp #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned READ_PORTS  = 2,
  parameter int unsigned WRITE_PORTS = 1,
  parameter int unsigned ZERO_REG    = 1
) (
  input  logic          clk,
  input  logic          reset_n,
  regfile_mp_if.slave   bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {SCRUB = 1'b0, READY = 1'b1} state_e;

  state_e                       state_q, state_d;
  logic [AW-1:0]                idx_q, idx_d;
  logic                         busy_q, busy_d;
  logic [READ_PORTS*WIDTH-1:0]  rs_out_q, rs_out_d;
  logic [WIDTH-1:0]             mem_q [DEPTH];

  logic [WRITE_PORTS-1:0]       wr_ok_c;
  logic [DEPTH-1:0]             wr_en_c;
  logic [WIDTH-1:0]             wr_val_c [DEPTH];
  logic [AW-1:0]                rsel_c;
  logic [WIDTH-1:0]             rval_c;

  // A write port is live only in READY and never when it targets a hardwired zero register.
  always_comb begin
    for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
      wr_ok_c[w] = (state_q == READY) && bus.rd_we[w] &&
                   !((ZERO_REG != 0) && (bus.rd_sel[w*AW +: AW] == '0));
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (state_q == SCRUB) begin
      idx_d = idx_q + AW'(1);
      if (idx_q == AW'(DEPTH - 1)) begin
        state_d = READY;
      end
    end
    busy_d = (state_d == SCRUB);
  end

  // Per-entry write resolution; ascending port order lets the highest port win.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      wr_en_c[i]  = 1'b0;
      wr_val_c[i] = '0;
      if ((state_q == SCRUB) && (idx_q == AW'(i))) begin
        wr_en_c[i] = 1'b1;
      end
      for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
        if (wr_ok_c[w] && (bus.rd_sel[w*AW +: AW] == AW'(i))) begin
          wr_en_c[i]  = 1'b1;
          wr_val_c[i] = bus.rd_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    rs_out_d = rs_out_q;
    rsel_c   = '0;
    rval_c   = '0;
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rsel_c = bus.rs_sel[p*AW +: AW];
      rval_c = mem_q[rsel_c];
      for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
        if (wr_ok_c[w] && (bus.rd_sel[w*AW +: AW] == rsel_c)) begin
          rval_c = bus.rd_data[w*WIDTH +: WIDTH];
        end
      end
      if ((ZERO_REG != 0) && (rsel_c == '0)) begin
        rval_c = '0;
      end
      if (state_q == SCRUB) begin
        rs_out_d[p*WIDTH +: WIDTH] = '0;
      end else if (bus.rs_en[p]) begin
        rs_out_d[p*WIDTH +: WIDTH] = rval_c;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= SCRUB;
      idx_q    <= '0;
      busy_q   <= 1'b1;
      rs_out_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      rs_out_q <= rs_out_d;
    end
  end

  // Storage is left out of the async reset; the scrub walk clears it.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (wr_en_c[i]) begin
        mem_q[i] <= wr_val_c[i];
      end
    end
  end

  assign bus.busy   = busy_q;
  assign bus.rs_out = rs_out_q;
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (ZERO_REG=1 and ZERO_REG=0) share one stimulus.
module tb_regfile_mp;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned RP = 2;
  localparam int unsigned WP = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .WRITE_PORTS(WP)) ifa ();
  regfile_mp_if #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .WRITE_PORTS(WP)) ifb ();

  assign ifb.rs_en   = ifa.rs_en;
  assign ifb.rs_sel  = ifa.rs_sel;
  assign ifb.rd_we   = ifa.rd_we;
  assign ifb.rd_sel  = ifa.rd_sel;
  assign ifb.rd_data = ifa.rd_data;

  regfile_mp #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .WRITE_PORTS(WP), .ZERO_REG(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  regfile_mp #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP), .WRITE_PORTS(WP), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  logic [31:0] a0, a1, b0, b1;
  assign a0 = ifa.rs_out[31:0];
  assign a1 = ifa.rs_out[63:32];
  assign b0 = ifb.rs_out[31:0];
  assign b1 = ifb.rs_out[63:32];

  int n_cmp = 0;
  int n_err = 0;
  int n;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [1:0] we, input logic [4:0] s0, input logic [31:0] d0,
                          input logic [4:0] s1, input logic [31:0] d1);
    ifa.rd_we   = we;
    ifa.rd_sel  = {s1, s0};
    ifa.rd_data = {d1, d0};
  endtask

  task automatic drive_rd(input logic [1:0] en, input logic [4:0] s0, input logic [4:0] s1);
    ifa.rs_en  = en;
    ifa.rs_sel = {s1, s0};
  endtask

  // Edges until busy drops, capped so a stuck scrub still reaches the summary.
  task automatic scrub_len(output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (ifa.busy && cnt < 100);
  endtask

  initial begin
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    drive_rd(2'b00, 5'd0, 5'd0);
    reset_n = 1'b0;
    tick();
    tick();
    chk("rst_busy", 32'(ifa.busy), 32'd1);
    chk("rst_out0", a0, 32'h0);
    chk("rst_out1", a1, 32'h0);

    // Scrub with a write attempt to entry 5 held throughout.
    reset_n = 1'b1;
    drive_wr(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    drive_rd(2'b11, 5'd5, 5'd5);
    scrub_len(n);
    chk("scrub_len", 32'(n), 32'd32);
    chk("scrub_rd", a0, 32'h0);
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive_rd(2'b11, 5'(i), 5'(31 - i));
      tick();
      chk("clr_a0", a0, 32'h0);
      chk("clr_a1", a1, 32'h0);
    end
    drive_rd(2'b11, 5'd5, 5'd5);
    tick();
    chk("clr5_a", a0, 32'h0);
    chk("clr5_b", b0, 32'h0);

    // Basic write then read, hold, per-port enable.
    drive_wr(2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0);
    drive_rd(2'b00, 5'd0, 5'd0);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    drive_rd(2'b11, 5'd7, 5'd7);
    tick();
    chk("rw_p0", a0, 32'h12345678);
    chk("rw_p1", a1, 32'h12345678);
    drive_rd(2'b00, 5'd1, 5'd2);
    tick();
    chk("hold_p0", a0, 32'h12345678);
    chk("hold_p1", a1, 32'h12345678);
    drive_rd(2'b10, 5'd7, 5'd1);
    tick();
    chk("en_p0", a0, 32'h12345678);
    chk("en_p1", a1, 32'h0);

    // Two ports hit reg 3: port 1 wins on bypass and in the array.
    drive_wr(2'b11, 5'd3, 32'hAAAA0000, 5'd3, 32'h5555FFFF);
    drive_rd(2'b11, 5'd3, 5'd3);
    tick();
    chk("byp_p0", a0, 32'h5555FFFF);
    chk("byp_p1", a1, 32'h5555FFFF);
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("byp_arr", a0, 32'h5555FFFF);
    drive_wr(2'b01, 5'd4, 32'h0BAD0004, 5'd4, 32'h77777777);
    drive_rd(2'b11, 5'd4, 5'd4);
    tick();
    chk("byp_we0", a0, 32'h0BAD0004);
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("arr_we0", a1, 32'h0BAD0004);

    // Register 0 write with same-cycle read.
    drive_wr(2'b01, 5'd0, 32'hFFFFFFFF, 5'd0, 32'h0);
    drive_rd(2'b11, 5'd0, 5'd0);
    tick();
    chk("zr_byp_a", a0, 32'h0);
    chk("zr_byp_b", b0, 32'hFFFFFFFF);
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    chk("zr_arr_a", a1, 32'h0);
    chk("zr_arr_b", b1, 32'hFFFFFFFF);

    // Fill every entry with index*0x01010101, two per cycle.
    for (int i = 0; i < 32; i += 2) begin
      drive_wr(2'b11, 5'(i), 32'(i) * 32'h01010101, 5'(i + 1), 32'(i + 1) * 32'h01010101);
      tick();
    end
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    drive_rd(2'b11, 5'd9, 5'd31);
    tick();
    chk("fill9", a0, 32'h09090909);
    chk("fill31", a1, 32'h1F1F1F1F);
    drive_rd(2'b11, 5'd0, 5'd16);
    tick();
    chk("fill0_b", b0, 32'h0);
    chk("fill16", a1, 32'h10101010);

    // Reset from READY: outputs clear asynchronously, then a full scrub.
    reset_n = 1'b0;
    #1;
    chk("arst_out", a1, 32'h0);
    chk("arst_busy", 32'(ifa.busy), 32'd1);
    tick();
    reset_n = 1'b1;
    scrub_len(n);
    chk("rescrub_len", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      drive_rd(2'b11, 5'(i), 5'(i));
      tick();
      chk("rescrub_a", a0, 32'h0);
      chk("rescrub_b", b1, 32'h0);
    end

    // Reset after 10 scrub edges restarts the full scrub.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", 32'(ifa.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_arst_busy", 32'(ifa.busy), 32'd1);
    chk("mid_arst_out", a0, 32'h0);
    tick();
    reset_n = 1'b1;
    scrub_len(n);
    chk("mid_scrub_len", 32'(n), 32'd32);

    // First write after busy falls is accepted.
    drive_wr(2'b01, 5'd9, 32'hC0FFEE09, 5'd0, 32'h0);
    drive_rd(2'b00, 5'd0, 5'd0);
    tick();
    drive_wr(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    drive_rd(2'b11, 5'd9, 5'd9);
    tick();
    chk("first_wr", a0, 32'hC0FFEE09);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the core's decode/writeback boundary. It replaces the fixed 2-read/1-write 32×32 file. It adds configurable width, depth and port counts, per-port read enables, priority-resolved multi-write bypass, and a post-reset scrub sequence that zeroes every entry while holding the pipeline off through `busy`.

## Interface
- `WIDTH`, 32, data bits per register
- `DEPTH`, 32, number of registers; power of two, ≥ 2; `AW = $clog2(DEPTH)`
- `READ_PORTS`, 2, number of read ports, ≥ 1
- `WRITE_PORTS`, 1, number of write ports, ≥ 1
- `ZERO_REG`, 1, when 1 register 0 reads as 0 and ignores writes
- `clk`  in  1  clock; all state changes on its rising edge
- `reset_n`  in  1  reset; one clock; asynchronous, active-low
- `busy`  out  1  scrub in progress; writes ignored, reads return 0
- `rs_en`  in  READ_PORTS  per-port read enable
- `rs_sel`  in  READ_PORTS*AW  read addresses, port p at bits [p*AW +: AW]
- `rs_out`  out  READ_PORTS*WIDTH  registered read data, port p at [p*WIDTH +: WIDTH]
- `rd_we`  in  WRITE_PORTS  per-port write enable
- `rd_sel`  in  WRITE_PORTS*AW  write addresses
- `rd_data`  in  WRITE_PORTS*WIDTH  write data

## Operation
- **FSM states**
  - SCRUB: entered asynchronously while `reset_n`=0. The scrub index resets to 0.
  - Each rising edge with `reset_n`=1 in SCRUB writes 0 to entry[index] and increments index.
  - On the edge that clears entry DEPTH-1, the FSM moves to READY.
  - READY is held until the next reset.
- **`busy`**
  - `busy`=1 exactly while in SCRUB.
- **Writes**, READY only
  - For each port w with `rd_we[w]`=1, `rd_data[w]` is written to entry `rd_sel[w]`.
  - When `ZERO_REG`=1, writes to address 0 are dropped.
  - Several ports writing the same address in one cycle: the highest-indexed port wins.
  - In SCRUB, all write ports are ignored.
- **Reads**
  - Per port p, updated only when `rs_en[p]`=1; otherwise `rs_out[p]` holds its value.
  - In SCRUB, `rs_out[p]` is loaded with 0 regardless of `rs_en`.
  - In READY, the result is the first match in this list:
    - 0 if `ZERO_REG`=1 and `rs_sel[p]`=0.
    - Write-first bypass: if any port w has `rd_we[w]`=1, `rd_sel[w]`=`rs_sel[p]`, and the write is not dropped, the result is `rd_data` of the highest such w.
    - Otherwise, entry[`rs_sel[p]`].
- **Zero register**
  - When `ZERO_REG`=0, entry 0 is an ordinary register.
- **Reset mid-operation**
  - Asserting `reset_n` at any point, including mid-scrub, immediately forces SCRUB with index 0, `busy`=1 and all `rs_out`=0.
  - Array contents need not be cleared asynchronously. The scrub restarts from entry 0.

## Timing
- **Reset values:**
  - `busy`=1
  - all `rs_out`=0
  - scrub index=0
  - state SCRUB
- **Scrub duration:**
  - Exactly DEPTH rising edges after `reset_n` deasserts. Edge k (1-based) clears entry k-1.
  - `busy` falls after edge DEPTH.
  - The first write accepted is on edge DEPTH+1, provided it is presented while `busy`=0.
- **Read latency:**
  - 1 cycle. Address presented in cycle n appears on `rs_out` after edge n, i.e. valid in cycle n+1.
- **Write latency:**
  - Entry updated at edge n.
  - A same-cycle read sees the new value via bypass.
  - Later reads see it from the array.
- **Same-edge ordering:**
  - The edge where `busy` falls is still SCRUB for read purposes, so `rs_out` is loaded with 0 on that edge.
- **No combinational paths** from inputs to `rs_out` or `busy`.

## Test plan
- **Scrub:** DEPTH=32. Release `reset_n` → `busy`=1 for exactly 32 edges, then 0. Then read all 32 entries → all 0. Writes attempted while `busy`=1 (addr 5, 0xDEADBEEF) → entry 5 reads 0.
- **Basic R/W:** Write 0x12345678 to reg 7. Read reg 7 on both ports the next cycle → both `rs_out`=0x12345678 one cycle later. Read with `rs_en`=0 → `rs_out` holds the previous value.
- **Bypass priority:** WRITE_PORTS=2, both write reg 3 (port0 0xAAAA0000, port1 0x5555FFFF), same-cycle read of reg 3 → `rs_out`=0x5555FFFF; a later read also gives 0x5555FFFF.
- **Zero register:** `ZERO_REG`=1, write 0xFFFFFFFF to reg 0 with a simultaneous read of reg 0 → `rs_out`=0, no bypass. `ZERO_REG`=0, same stimulus → 0xFFFFFFFF.
- **Reset mid-scrub:** Assert `reset_n`=0 after 10 scrub edges, release → `busy` stays 1 for a full 32 further edges. `rs_out`=0 asynchronously during reset.
- **Reset in READY:** Fill all regs with index×0x01010101, pulse `reset_n` → `busy`=1 for 32 edges, then all entries read 0.
